// File: rtl/io_switch_bank_if.sv
// io_switch_bank_if: bus, switch and event signals of the switch bank; irq exists only with SWBANK_IRQ_EN
interface io_switch_bank_if #(parameter int CHANNELS = 8);
  logic [CHANNELS-1:0] sig;
  logic [CHANNELS-1:0] stb;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [1:0] addr;
  logic we;
  logic [31:0] wdata;
  logic [31:0] rdata;
`ifdef SWBANK_IRQ_EN
  logic irq;
  modport master (output sig, addr, we, wdata, input stb, rise, fall, rdata, irq);
  modport slave (input sig, addr, we, wdata, output stb, rise, fall, rdata, irq);
`else
  modport master (output sig, addr, we, wdata, input stb, rise, fall, rdata);
  modport slave (input sig, addr, we, wdata, output stb, rise, fall, rdata);
`endif
endinterface

// File: rtl/io_switch_bank.sv
// io_switch_bank: synchronized, debounced switch inputs with edge pulses, W1C flags; SWBANK_IRQ_EN adds mask + irq
module io_switch_bank #(
  parameter int CHANNELS = 8,
  parameter int STABLE_CNT = 16,
  parameter int SAMPLE_DIV = 4
) (
  input logic clk,
  input logic rst,
  io_switch_bank_if.slave bus
);
  localparam logic [7:0] LAST = 8'(STABLE_CNT - 1);
  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
  logic [CHANNELS-1:0] s1, s2, stb, rise, fall, flags, ev, clr, mask;
  logic [7:0] cnt [CHANNELS];
  logic [15:0] div;
  logic tick;
  assign tick = div == DIV_LAST;
  assign clr = (bus.we && bus.addr == 2'd1) ? bus.wdata[CHANNELS-1:0] : '0;
  // a channel flips when its window completes on a tick while the sample still disagrees
  always_comb begin
    ev = '0;
    for (int i = 0; i < CHANNELS; i++) ev[i] = tick && (s2[i] != stb[i]) && (cnt[i] == LAST);
  end
  // synchronizer, sample divider, per-channel debounce counters and edge pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      div <= '0;
      stb <= '0;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      s1 <= bus.sig;
      s2 <= s1;
      div <= tick ? '0 : div + 16'd1;
      stb <= stb ^ ev;
      rise <= ev & s2;
      fall <= ev & ~s2;
      if (tick)
        for (int i = 0; i < CHANNELS; i++) cnt[i] <= (s2[i] == stb[i] || ev[i]) ? '0 : cnt[i] + 8'd1;
    end
  end
  // sticky event flags; a new event wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst) flags <= '0;
    else flags <= (flags & ~clr) | ev;
  end
`ifdef SWBANK_IRQ_EN
  logic irq;
  // mask register and registered interrupt from masked flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask <= '0;
      irq <= 1'b0;
    end else begin
      if (bus.we && bus.addr == 2'd2) mask <= bus.wdata[CHANNELS-1:0];
      irq <= |(flags & mask);
    end
  end
  assign bus.irq = irq;
`else
  assign mask = '0;
`endif
  assign bus.stb = stb;
  assign bus.rise = rise;
  assign bus.fall = fall;
  assign bus.rdata = bus.addr == 2'd0 ? 32'(stb) :
                     bus.addr == 2'd1 ? 32'(flags) :
                     bus.addr == 2'd2 ? 32'(mask) : 32'd0;
endmodule

// File: tb/tb_io_switch_bank.sv
// tb_io_switch_bank: directed checks of debounce, edges, W1C flags, bus decode; irq checks when SWBANK_IRQ_EN is set
module tb_io_switch_bank;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  io_switch_bank_if #(.CHANNELS(8)) b ();
  io_switch_bank_if #(.CHANNELS(32)) b32 ();
  io_switch_bank #(.CHANNELS(8), .STABLE_CNT(4), .SAMPLE_DIV(2)) dut (.clk(clk), .rst(rst), .bus(b));
  io_switch_bank #(.CHANNELS(32), .STABLE_CNT(4), .SAMPLE_DIV(1)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    b.addr = a;
    #1 d = b.rdata;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    b.addr = a;
    b.wdata = d;
    b.we = 1'b1;
    @(negedge clk);
    b.we = 1'b0;
  endtask
  task automatic wait_stb(input int ch, input logic val, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b.stb[ch] !== val && n < 40);
  endtask
  initial begin
    logic [31:0] d;
    int n;
    logic saw;
    rst = 1'b0;
    b.sig = 8'hFF;
    b.we = 1'b0;
    b.addr = 2'd0;
    b.wdata = '0;
    b32.sig = '0;
    b32.we = 1'b0;
    b32.addr = 2'd0;
    b32.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_stb", 32'(b.stb), 0);
    check("rst_rise", 32'(b.rise), 0);
    check("rst_fall", 32'(b.fall), 0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check($sformatf("rst_rdata%0d", a), d, 0);
    end
    rst = 1'b1;
    wait_stb(7, 1'b1, n);
    check("rst_lat_ok", 32'(n >= 9 && n <= 11), 1);
    check("rel_stb", 32'(b.stb), 32'hFF);
    check("rel_rise", 32'(b.rise), 32'hFF);
    rd(1, d);
    check("rel_flags", d, 32'hFF);
    @(negedge clk);
    check("rel_rise_gone", 32'(b.rise), 0);
    wr(0, 32'h0);
    rd(0, d);
    check("wr_addr0_ignored", d, 32'hFF);
    wr(1, 32'hFFFF_FFFF);
    rd(1, d);
    check("w1c_all", d, 0);
    b.sig = 8'h00;
    wait_stb(7, 1'b0, n);
    check("fall_stb", 32'(b.stb), 0);
    check("fall_pulse", 32'(b.fall), 32'hFF);
    wr(1, 32'hFF);
    saw = 1'b0;
    b.sig[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      saw |= b.rise[0];
    end
    b.sig[0] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw |= b.rise[0];
    end
    check("glitch_stb", 32'(b.stb[0]), 0);
    check("glitch_rise", 32'(saw), 0);
    rd(1, d);
    check("glitch_flags", d, 0);
    b.sig[3] = 1'b1;
    wait_stb(3, 1'b1, n);
    check("step_lat_ok", 32'(n >= 9 && n <= 11), 1);
    check("step_rise", 32'(b.rise), 32'h08);
    rd(1, d);
    check("step_flags", d, 32'h08);
    @(negedge clk);
    check("step_rise_gone", 32'(b.rise), 0);
    wr(1, 32'h08);
    rd(1, d);
    check("step_w1c", d, 0);
    b.sig[5] = 1'b1;
    wait_stb(5, 1'b1, n);
    wr(1, 32'hFF);
    b.addr = 2'd1;
    b.wdata = 32'h20;
    b.we = 1'b1;
    b.sig[5] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b.fall[5] && n < 40);
    b.we = 1'b0;
    check("coll_fall", 32'(b.fall), 32'h20);
    rd(1, d);
    check("coll_flag_kept", d, 32'h20);
    wr(1, 32'hFF);
    b.sig = b.sig | 8'hC0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b.rise == 0 && n < 40);
    check("multi_rise", 32'(b.rise), 32'hC0);
    rd(1, d);
    check("multi_flags", d, 32'hC0);
    rd(0, d);
    check("multi_stb", d, 32'hC8);
    wr(1, 32'hFF);
`ifdef SWBANK_IRQ_EN
    wr(2, 32'h04);
    rd(2, d);
    check("mask_rd", d, 32'h04);
    b.sig[2] = 1'b1;
    wait_stb(2, 1'b1, n);
    check("irq_before", 32'(b.irq), 0);
    @(negedge clk);
    check("irq_set", 32'(b.irq), 1);
    wr(1, 32'h04);
    @(negedge clk);
    check("irq_clr", 32'(b.irq), 0);
    b.sig[1] = 1'b1;
    wait_stb(1, 1'b1, n);
    repeat (2) @(negedge clk);
    check("irq_masked", 32'(b.irq), 0);
`else
    wr(2, 32'hFF);
    rd(2, d);
    check("addr2_zero", d, 0);
`endif
    wr(3, 32'hFF);
    rd(3, d);
    check("addr3_zero", d, 0);
    check("wide_idle", b32.rdata, 0);
    b32.sig[31] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b32.rdata[31] && n < 40);
    check("wide_lat_ok", 32'(n >= 5 && n <= 7), 1);
    check("wide_rdata", b32.rdata, 32'h8000_0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
